// File: rtl/alu_exec_sequencer.sv
// ---------------------------------------------------------------------------
// alu_exec_sequencer
//
// Multi-cycle control unit for the execute path. It accepts one instruction
// word at a time, latches and decodes it, and then steps through:
//   IDLE -> READ -> EXEC -> WAIT -> (MEM) -> (WB) -> DONE -> IDLE
// It strobes the registered ALU for one cycle, runs the data-memory access
// with a timeout, issues the register-file write and resolves CMP/BEQ flags.
// Only one instruction is ever in flight.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   instr               [31:28] op, [27:23] rd, [22:18] rs1, [13:9] rs2,
//                       [8:4] sa, [13:0] imm
//   alu_op, alu_enable  ALU opcode (held) and one-cycle evaluate strobe
//   rs1/rs2/rd_addr     register-file addresses (held until next accept)
//   imm, sa             immediate and shift amount (held)
//   alu_zero            ALU zero/compare flag, sampled in WAIT
//   mem_req/we/ack      data-memory request, store select, completion
//   rf_we, rf_src_mem   register-file write strobe and writeback source
//   branch_taken        BEQ outcome, valid with done
//   cmp_flag            latched CMP result
//   done                one-cycle completion pulse
//   illegal, mem_err    error pulses coincident with done
// ---------------------------------------------------------------------------
module alu_exec_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        alu_enable,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [13:0] imm,
  output logic [4:0]  sa,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic        rf_src_mem,
  output logic        branch_taken,
  output logic        cmp_flag,
  output logic        done,
  output logic        illegal,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WAIT,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h6;
  localparam logic [3:0] OP_SW  = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;

  // Last counter value at which a missing ack still allows one more MEM
  // cycle; the request is therefore held for exactly MEM_TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  function automatic logic op_illegal(input logic [3:0] op);
    return (op == 4'h9) || (op == 4'hA) || (op == 4'hF);
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              cmp_q, cmp_d;
  logic              bt_q, bt_d;
  logic              err_q, err_d;
  // Low through reset and for the first edge after it, so instr_ready only
  // rises the cycle after reset is released.
  logic              run_q, run_d;
  logic [3:0]        op_q;
  logic              unused_instr_bits;

  assign op_q              = instr_q[31:28];
  assign unused_instr_bits = ^instr_q[17:14];

  // Decode fields come straight from the latched word.
  assign alu_op       = op_q;
  assign rd_addr      = instr_q[27:23];
  assign rs1_addr     = instr_q[22:18];
  assign rs2_addr     = instr_q[13:9];
  assign sa           = instr_q[8:4];
  assign imm          = instr_q[13:0];
  assign branch_taken = bt_q;
  assign cmp_flag     = cmp_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      cmp_q   <= 1'b0;
      bt_q    <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      bt_q    <= bt_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    cmp_d       = cmp_q;
    bt_d        = bt_q;
    err_d       = err_q;
    run_d       = 1'b1;
    instr_ready = 1'b0;
    alu_enable  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_we       = 1'b0;
    rf_src_mem  = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = run_q;
        if (run_q && instr_valid) begin
          instr_d = instr;
          err_d   = 1'b0;
          // BEQ keeps the previous outcome visible until it resolves.
          if (instr[31:28] != OP_BEQ) begin
            bt_d = 1'b0;
          end
          state_d = S_READ;
        end
      end

      S_READ: begin
        state_d = op_illegal(op_q) ? S_DONE : S_EXEC;
      end

      S_EXEC: begin
        alu_enable = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        case (op_q)
          OP_CMP: begin
            cmp_d   = alu_zero;
            state_d = S_DONE;
          end
          OP_BEQ: begin
            bt_d    = alu_zero;
            state_d = S_DONE;
          end
          OP_LW, OP_SW: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          default: begin
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
        cnt_d   = cnt_q + TO_W'(1);
        // An ack on the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_d = (op_q == OP_LW) ? S_WB : S_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        rf_src_mem = (op_q == OP_LW);
        state_d    = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        illegal = op_illegal(op_q);
        mem_err = err_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [13:0] imm;
  logic [4:0]  sa;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        rf_we;
  logic        rf_src_mem;
  logic        branch_taken;
  logic        cmp_flag;
  logic        done;
  logic        illegal;
  logic        mem_err;

  int n_chk;
  int n_bad;

  // Per-instruction observations, cycle numbers counted from the accept edge.
  int   r_done, r_aen_n, r_aen_cyc, r_we_n, r_we_cyc, r_mreq_n, r_rdy_lo;
  logic r_src, r_mwe_any, r_mwe_all, r_ill, r_merr, r_bt, r_cmp, r_bt_c1;

  alu_exec_sequencer #(
    .MEM_TIMEOUT(4),
    .TO_W       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_enable  (alu_enable),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .imm         (imm),
    .sa          (sa),
    .alu_zero    (alu_zero),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .rf_we       (rf_we),
    .rf_src_mem  (rf_src_mem),
    .branch_taken(branch_taken),
    .cmp_flag    (cmp_flag),
    .done        (done),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] s);
    return {op, rd, rs1, 4'b0000, rs2, s, 4'b0000};
  endfunction

  // Issue one instruction and watch it to completion. ack_at = n asserts
  // mem_ack during the n-th cycle of mem_req (0 = never).
  task automatic run(input string tag, input logic [31:0] w, input int ack_at);
    int mq;
    mq        = 0;
    r_done    = 0;
    r_aen_n   = 0;
    r_aen_cyc = 0;
    r_we_n    = 0;
    r_we_cyc  = 0;
    r_rdy_lo  = 0;
    r_src     = 1'b0;
    r_mwe_any = 1'b0;
    r_mwe_all = 1'b1;
    r_ill     = 1'b0;
    r_merr    = 1'b0;
    r_bt      = 1'b0;
    r_cmp     = 1'b0;
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    r_bt_c1     = branch_taken;
    for (int c = 1; c <= 40; c++) begin
      if (!instr_ready) r_rdy_lo++;
      if (alu_enable) begin
        r_aen_n++;
        r_aen_cyc = c;
      end
      if (rf_we) begin
        r_we_n++;
        r_we_cyc = c;
        r_src    = rf_src_mem;
      end
      if (mem_req) begin
        mq++;
        r_mwe_any = r_mwe_any | mem_we;
        r_mwe_all = r_mwe_all & mem_we;
        mem_ack   = (mq == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        r_done = c;
        r_ill  = illegal;
        r_merr = mem_err;
        r_bt   = branch_taken;
        r_cmp  = cmp_flag;
        break;
      end
      step();
    end
    r_mreq_n = mq;
    mem_ack  = 1'b0;
    step();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_back"}, int'(instr_ready), 1);
  endtask

  initial begin
    n_chk       = 0;
    n_bad       = 0;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    mem_ack     = 1'b0;
    alu_zero    = 1'b0;
    step();
    step();
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mreq", int'(mem_req), 0);
    chk("rst_aop", int'(alu_op), 0);
    chk("rst_rd", int'(rd_addr), 0);
    chk("rst_bt", int'(branch_taken), 0);
    chk("rst_cmp", int'(cmp_flag), 0);
    chk("rst_rfwe", int'(rf_we), 0);
    reset = 1'b1;
    step();
    chk("rdy_after_rst", int'(instr_ready), 1);

    // ADD rd=3 rs1=1 rs2=2
    run("add", mk(4'h1, 5'd3, 5'd1, 5'd2, 5'd0), 0);
    chk("add_aop", int'(alu_op), 1);
    chk("add_rd", int'(rd_addr), 3);
    chk("add_rs1", int'(rs1_addr), 1);
    chk("add_rs2", int'(rs2_addr), 2);
    chk("add_imm", int'(imm), 32'h400);
    chk("add_aen_n", r_aen_n, 1);
    chk("add_aen_cyc", r_aen_cyc, 2);
    chk("add_we_n", r_we_n, 1);
    chk("add_we_cyc", r_we_cyc, 4);
    chk("add_src", int'(r_src), 0);
    chk("add_done", r_done, 5);
    chk("add_rdy_lo", r_rdy_lo, 5);
    chk("add_ill", int'(r_ill), 0);
    chk("add_mreq", r_mreq_n, 0);

    // SLL rd=4 rs1=5 sa=7
    run("sll", mk(4'hB, 5'd4, 5'd5, 5'd0, 5'd7), 0);
    chk("sll_aop", int'(alu_op), 11);
    chk("sll_sa", int'(sa), 7);
    chk("sll_done", r_done, 5);

    // LW, ack in third MEM cycle
    run("lw", mk(4'h6, 5'd7, 5'd2, 5'd0, 5'd0), 3);
    chk("lw_mreq", r_mreq_n, 3);
    chk("lw_mwe", int'(r_mwe_any), 0);
    chk("lw_we_n", r_we_n, 1);
    chk("lw_we_cyc", r_we_cyc, 7);
    chk("lw_src", int'(r_src), 1);
    chk("lw_done", r_done, 8);
    chk("lw_merr", int'(r_merr), 0);

    // SW, immediate ack
    run("sw", mk(4'h7, 5'd0, 5'd2, 5'd3, 5'd0), 1);
    chk("sw_mreq", r_mreq_n, 1);
    chk("sw_mwe", int'(r_mwe_all), 1);
    chk("sw_we_n", r_we_n, 0);
    chk("sw_done", r_done, 5);
    chk("sw_merr", int'(r_merr), 0);

    // BEQ taken, BEQ not taken, BEQ taken, then ADD clears the flag
    alu_zero = 1'b1;
    run("beq1", mk(4'h8, 5'd0, 5'd1, 5'd2, 5'd0), 0);
    chk("beq1_done", r_done, 4);
    chk("beq1_bt", int'(r_bt), 1);
    chk("beq1_we_n", r_we_n, 0);
    chk("beq1_aen_n", r_aen_n, 1);
    chk("beq1_hold", int'(branch_taken), 1);
    alu_zero = 1'b0;
    run("beq2", mk(4'h8, 5'd0, 5'd1, 5'd2, 5'd0), 0);
    chk("beq2_bt_c1", int'(r_bt_c1), 1);
    chk("beq2_bt", int'(r_bt), 0);
    alu_zero = 1'b1;
    run("beq3", mk(4'h8, 5'd0, 5'd3, 5'd4, 5'd0), 0);
    chk("beq3_bt", int'(r_bt), 1);
    run("add2", mk(4'h1, 5'd1, 5'd1, 5'd1, 5'd0), 0);
    chk("add2_bt_c1", int'(r_bt_c1), 0);
    chk("add2_bt", int'(r_bt), 0);

    // CMP true then false
    run("cmp1", mk(4'h3, 5'd0, 5'd1, 5'd2, 5'd0), 0);
    chk("cmp1_done", r_done, 4);
    chk("cmp1_flag", int'(r_cmp), 1);
    chk("cmp1_we_n", r_we_n, 0);
    alu_zero = 1'b0;
    run("cmp2", mk(4'h3, 5'd0, 5'd1, 5'd2, 5'd0), 0);
    chk("cmp2_flag", int'(r_cmp), 0);

    // Illegal opcodes
    run("illA", mk(4'hA, 5'd1, 5'd1, 5'd1, 5'd0), 0);
    chk("illA_done", r_done, 2);
    chk("illA_aen_n", r_aen_n, 0);
    chk("illA_ill", int'(r_ill), 1);
    chk("illA_we_n", r_we_n, 0);
    run("ill9", mk(4'h9, 5'd1, 5'd1, 5'd1, 5'd0), 0);
    chk("ill9_ill", int'(r_ill), 1);
    run("illF", mk(4'hF, 5'd1, 5'd1, 5'd1, 5'd0), 0);
    chk("illF_done", r_done, 2);

    // SW with no ack: times out after 4 MEM cycles
    run("swto", mk(4'h7, 5'd0, 5'd2, 5'd3, 5'd0), 0);
    chk("swto_mreq", r_mreq_n, 4);
    chk("swto_done", r_done, 8);
    chk("swto_merr", int'(r_merr), 1);
    chk("swto_we_n", r_we_n, 0);
    mem_ack = 1'b1;
    step();
    chk("late_ack_mreq", int'(mem_req), 0);
    chk("late_ack_done", int'(done), 0);
    step();
    mem_ack = 1'b0;
    chk("late_ack_ready", int'(instr_ready), 1);
    chk("late_ack_merr", int'(mem_err), 0);

    // Reset while an LW sits in MEM
    instr       = mk(4'h6, 5'd9, 5'd2, 5'd0, 5'd0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    step();
    chk("rlw_in_mem", int'(mem_req), 1);
    reset = 1'b0;
    step();
    chk("rlw_mreq", int'(mem_req), 0);
    chk("rlw_done", int'(done), 0);
    chk("rlw_rfwe", int'(rf_we), 0);
    chk("rlw_ready", int'(instr_ready), 0);
    chk("rlw_aop", int'(alu_op), 0);
    step();
    chk("rlw_ready2", int'(instr_ready), 0);
    reset = 1'b1;
    step();
    chk("rlw_ready_back", int'(instr_ready), 1);
    chk("rlw_done2", int'(done), 0);

    run("add3", mk(4'h2, 5'd6, 5'd4, 5'd5, 5'd0), 0);
    chk("add3_done", r_done, 5);
    chk("add3_we_n", r_we_n, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
